// File: rtl/ysyx_23060208_pkg.sv
// Shared types and constants for the ysyx_23060208 instruction fetch unit.
// Holds fetch FSM encodings, response codes and the default boot address.
package ysyx_23060208_pkg;

    typedef enum logic [1:0] {
        IFU_IDLE = 2'd0,
        IFU_AR   = 2'd1,
        IFU_R    = 2'd2,
        IFU_HOLD = 2'd3
    } ifu_state_e;

    localparam logic [1:0]  RESP_OKAY      = 2'b00;
    localparam int          INST_BYTES     = 4;
    localparam logic [31:0] DEF_RESET_PC   = 32'h8000_0000;

endpackage

// File: rtl/ysyx_23060208_ifu_pc.sv
// Program counter for the fetch unit: sequential advance with redirect priority.
// pc_next_o exposes the next-state value so the fetcher can latch it on AR entry.
module ysyx_23060208_ifu_pc
    import ysyx_23060208_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(DEF_RESET_PC)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  advance_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] pc_next_o
);

    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = redirect_pc_i;
        end else if (advance_i) begin
            pc_d = pc_q + DATA_WIDTH'(INST_BYTES);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o      = pc_q;
    assign pc_next_o = pc_d;

endmodule

// File: rtl/ysyx_23060208_ifu_fetch.sv
// Instruction fetch master: one AR/R read per instruction, buffered for the IDU.
// Redirects retarget the PC at any time; stale in-flight responses are dropped.
module ysyx_23060208_ifu_fetch
    import ysyx_23060208_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(DEF_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [DATA_WIDTH-1:0] isram_araddr,
    output logic                  isram_arvalid,
    input  logic                  isram_arready,
    input  logic [1:0]            isram_rresp,
    input  logic                  isram_rvalid,
    input  logic [DATA_WIDTH-1:0] isram_rdata,
    output logic                  isram_rready,
    output logic                  ifu_allowin,
    input  logic                  idu_allowin,
    output logic                  ifu_to_idu_valid,
    output logic [DATA_WIDTH-1:0] ifu_to_idu_inst,
    output logic [DATA_WIDTH-1:0] ifu_to_idu_pc,
    output logic                  ifu_to_idu_fault,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc
);

    ifu_state_e            state_q, state_d;
    logic                  drop_q, drop_d;
    logic                  fault_q, fault_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] inst_q, inst_d;
    logic [DATA_WIDTH-1:0] ipc_q, ipc_d;
    logic                  advance;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_next;

    ysyx_23060208_ifu_pc #(
        .DATA_WIDTH (DATA_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_pc (
        .clk_i         (clk),
        .rst_ni        (rst),
        .advance_i     (advance),
        .redirect_i    (redirect_valid),
        .redirect_pc_i (redirect_pc),
        .pc_o          (pc),
        .pc_next_o     (pc_next)
    );

    always_comb begin
        state_d = state_q;
        drop_d  = drop_q;
        fault_d = fault_q;
        inst_d  = inst_q;
        ipc_d   = ipc_q;
        advance = 1'b0;
        unique case (state_q)
            IFU_IDLE: state_d = IFU_AR;
            IFU_AR: begin
                if (redirect_valid) drop_d = 1'b1;
                if (isram_arready) state_d = IFU_R;
            end
            IFU_R: begin
                if (isram_rvalid) begin
                    drop_d = 1'b0;
                    if (drop_q || redirect_valid) begin
                        state_d = IFU_AR;
                    end else begin
                        inst_d  = isram_rdata;
                        ipc_d   = addr_q;
                        fault_d = (isram_rresp != RESP_OKAY);
                        state_d = IFU_HOLD;
                    end
                end else if (redirect_valid) begin
                    drop_d = 1'b1;
                end
            end
            IFU_HOLD: begin
                advance = idu_allowin;
                if (idu_allowin || redirect_valid) state_d = IFU_AR;
            end
            default: state_d = IFU_IDLE;
        endcase
    end

    // Address is captured only on AR entry so it stays stable under redirects.
    always_comb begin
        addr_d = addr_q;
        if (state_d == IFU_AR && state_q != IFU_AR) addr_d = pc_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IFU_IDLE;
            drop_q  <= 1'b0;
            fault_q <= 1'b0;
            addr_q  <= RESET_PC;
            inst_q  <= '0;
            ipc_q   <= '0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            fault_q <= fault_d;
            addr_q  <= addr_d;
            inst_q  <= inst_d;
            ipc_q   <= ipc_d;
        end
    end

    assign isram_araddr     = addr_q;
    assign isram_arvalid    = (state_q == IFU_AR);
    assign isram_rready     = (state_q == IFU_R);
    assign ifu_allowin      = (state_q != IFU_HOLD);
    assign ifu_to_idu_valid = (state_q == IFU_HOLD);
    assign ifu_to_idu_inst  = inst_q;
    assign ifu_to_idu_pc    = ipc_q;
    assign ifu_to_idu_fault = fault_q;

endmodule

// File: tb/tb_ysyx_23060208_ifu_fetch.sv
// Directed bench for the fetch unit with a behavioural isram slave.
// Table of fetch vectors plus hand-written hold/redirect/reset sequences.
module tb_ysyx_23060208_ifu_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] isram_araddr;
    logic        isram_arvalid;
    logic        isram_arready;
    logic [1:0]  isram_rresp;
    logic        isram_rvalid;
    logic [31:0] isram_rdata;
    logic        isram_rready;
    logic        ifu_allowin;
    logic        idu_allowin;
    logic        ifu_to_idu_valid;
    logic [31:0] ifu_to_idu_inst;
    logic [31:0] ifu_to_idu_pc;
    logic        ifu_to_idu_fault;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    ysyx_23060208_ifu_fetch dut (
        .clk              (clk),
        .rst              (rst),
        .isram_araddr     (isram_araddr),
        .isram_arvalid    (isram_arvalid),
        .isram_arready    (isram_arready),
        .isram_rresp      (isram_rresp),
        .isram_rvalid     (isram_rvalid),
        .isram_rdata      (isram_rdata),
        .isram_rready     (isram_rready),
        .ifu_allowin      (ifu_allowin),
        .idu_allowin      (idu_allowin),
        .ifu_to_idu_valid (ifu_to_idu_valid),
        .ifu_to_idu_inst  (ifu_to_idu_inst),
        .ifu_to_idu_pc    (ifu_to_idu_pc),
        .ifu_to_idu_fault (ifu_to_idu_fault),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0413;
        return {a[15:0], 16'h0093};
    endfunction

    // Behavioural slave: arready from the bench, rvalid r_delay cycles after AR.
    logic        arready_en;
    int          r_delay;
    logic [1:0]  resp_sel;
    logic        s_pend;
    int          s_cnt;
    logic [31:0] s_addr;

    assign isram_arready = arready_en;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            isram_rvalid <= 1'b0;
            isram_rdata  <= '0;
            isram_rresp  <= 2'b00;
            s_pend       <= 1'b0;
            s_cnt        <= 0;
            s_addr       <= '0;
        end else begin
            if (isram_rvalid && isram_rready) isram_rvalid <= 1'b0;
            if (isram_arvalid && isram_arready) begin
                s_addr <= isram_araddr;
                if (r_delay == 0) begin
                    isram_rvalid <= 1'b1;
                    isram_rdata  <= memf(isram_araddr);
                    isram_rresp  <= resp_sel;
                end else begin
                    s_pend <= 1'b1;
                    s_cnt  <= r_delay - 1;
                end
            end else if (s_pend) begin
                if (s_cnt == 0) begin
                    s_pend       <= 1'b0;
                    isram_rvalid <= 1'b1;
                    isram_rdata  <= memf(s_addr);
                    isram_rresp  <= resp_sel;
                end else begin
                    s_cnt <= s_cnt - 1;
                end
            end
        end
    end

    int vcnt;
    initial vcnt = 0;
    always @(negedge clk) if (ifu_to_idu_valid) vcnt++;

    int n_pass;
    int n_total;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0: return isram_arvalid;
            1: return isram_rready;
            default: return ifu_to_idu_valid;
        endcase
    endfunction

    task automatic wait_for(input int sel, input string name);
        int n;
        n = 0;
        while (!sig(sel) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!sig(sel)) begin
            n_total++;
            $display("FAIL timeout %s: got 0 expected 1", name);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  resp;
        logic [31:0] inst;
        logic        fault;
    } vec_t;

    vec_t        tbl[4];
    logic [31:0] h_inst;
    logic [31:0] h_pc;
    int          v0;

    initial begin
        n_pass = 0;
        n_total = 0;
        tbl[0] = '{32'h8000_0000, 2'b00, 32'h0000_0413, 1'b0};
        tbl[1] = '{32'h8000_0004, 2'b10, 32'h0004_0093, 1'b1};
        tbl[2] = '{32'h8000_0008, 2'b00, 32'h0008_0093, 1'b0};
        tbl[3] = '{32'h8000_000C, 2'b11, 32'h000C_0093, 1'b1};

        rst = 1'b1;
        arready_en = 1'b1;
        r_delay = 0;
        resp_sel = 2'b00;
        idu_allowin = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ctrl", {28'd0, isram_arvalid, isram_rready,
            ifu_to_idu_valid, ifu_allowin}, 32'h1);
        chk("rst_fault", {31'd0, ifu_to_idu_fault}, 32'h0);
        chk("rst_inst", ifu_to_idu_inst, 32'h0);
        chk("rst_pc", ifu_to_idu_pc, 32'h0);

        rst = 1'b1;
        chk("idle_arvalid", {31'd0, isram_arvalid}, 32'h0);
        @(negedge clk);
        chk("ar_after_idle", {31'd0, isram_arvalid}, 32'h1);

        for (int i = 0; i < 4; i++) begin
            resp_sel = tbl[i].resp;
            wait_for(0, "tbl_ar");
            chk($sformatf("tbl%0d_araddr", i), isram_araddr, tbl[i].addr);
            wait_for(2, "tbl_valid");
            chk($sformatf("tbl%0d_pc", i), ifu_to_idu_pc, tbl[i].addr);
            chk($sformatf("tbl%0d_inst", i), ifu_to_idu_inst, tbl[i].inst);
            chk($sformatf("tbl%0d_fault", i), {31'd0, ifu_to_idu_fault},
                {31'd0, tbl[i].fault});
        end
        resp_sel = 2'b00;

        // IDU stall: buffer must hold steady with no new AR.
        @(posedge clk);
        #1 idu_allowin = 1'b0;
        wait_for(2, "hold_valid");
        chk("hold_pc0", ifu_to_idu_pc, 32'h8000_0010);
        h_inst = ifu_to_idu_inst;
        h_pc = ifu_to_idu_pc;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("hold%0d_ctrl", c), {30'd0, ifu_to_idu_valid,
                isram_arvalid}, 32'h2);
            chk($sformatf("hold%0d_buf", c), ifu_to_idu_inst ^ ifu_to_idu_pc,
                h_inst ^ h_pc);
        end
        r_delay = 3;
        idu_allowin = 1'b1;
        wait_for(0, "hold_next_ar");
        chk("hold_next_araddr", isram_araddr, 32'h8000_0014);

        // Redirect while waiting in R.
        wait_for(1, "r_state");
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0100;
        v0 = vcnt;
        @(negedge clk);
        redirect_valid = 1'b0;
        wait_for(0, "redir_r_ar");
        chk("redir_r_araddr", isram_araddr, 32'h8000_0100);
        chk("redir_r_novalid", 32'(vcnt), 32'(v0));
        r_delay = 0;
        wait_for(2, "redir_r_valid");
        chk("redir_r_pc", ifu_to_idu_pc, 32'h8000_0100);
        chk("redir_r_inst", ifu_to_idu_inst, memf(32'h8000_0100));

        // Redirect while AR is stalled by arready.
        arready_en = 1'b0;
        wait_for(0, "stall_ar");
        chk("stall_c1_addr", isram_araddr, 32'h8000_0104);
        v0 = vcnt;
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0200;
        chk("stall_c2_addr", isram_araddr, 32'h8000_0104);
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("stall_c3_addr", {isram_araddr[30:0], isram_arvalid},
            {31'h0000_0104, 1'b1});
        arready_en = 1'b1;
        @(negedge clk);
        wait_for(0, "stall_redir_ar");
        chk("stall_redir_addr", isram_araddr, 32'h8000_0200);
        chk("stall_novalid", 32'(vcnt), 32'(v0));
        wait_for(2, "stall_redir_valid");
        chk("stall_redir_pc", ifu_to_idu_pc, 32'h8000_0200);

        // Async reset in the middle of a read.
        r_delay = 3;
        wait_for(1, "rst_r_state");
        #2 rst = 1'b0;
        #1;
        chk("async_rst_ctrl", {29'd0, isram_arvalid, isram_rready,
            ifu_to_idu_valid}, 32'h0);
        chk("async_rst_pc", ifu_to_idu_pc, 32'h0);
        @(negedge clk);
        r_delay = 0;
        rst = 1'b1;
        wait_for(0, "restart_ar");
        chk("restart_araddr", isram_araddr, 32'h8000_0000);
        wait_for(2, "restart_valid");
        chk("restart_inst", ifu_to_idu_inst, 32'h0000_0413);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
